// File: rtl/seg7_ctrl_if.sv
// seg7_ctrl_if: CPU data-bus slice seen by the seven-segment display
// register. The master side (address decoder / CPU) drives chip select,
// write strobe and write data; the slave side returns read data.
//
// Handshake: there is none. seg7_cs qualified by we is a write that the slave
// captures on that same rising edge; seg7_cs with we low is a read whose data
// is valid combinationally in the same cycle. No wait states, no back-pressure:
// a new access can be presented every cycle.
interface seg7_ctrl_if;
  logic        seg7_cs;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output seg7_cs,
    output we,
    output wdata,
    input  rdata
  );

  modport slave (
    input  seg7_cs,
    input  we,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/seg7_ctrl.sv
// seg7_ctrl: memory-mapped eight-digit common-anode seven-segment driver.
// Holds one 32-bit word written over the bus, returns it on reads, and scans
// its eight hex nibbles across the display, SCAN_DIV clock cycles per digit.
// Optional feature macro: SEG7_BLANK_LEADING_ZERO_EN (blank leading zeros).
module seg7_ctrl #(
  parameter int SCAN_DIV = 100000
) (
  input  logic            clk,
  input  logic            rst_n,
  seg7_ctrl_if.slave      bus,
  output logic [7:0]      an,
  output logic [7:0]      seg
);

  // Prescaler is sized for the largest legal SCAN_DIV (2^20).
  localparam logic [19:0] CNT_MAX = 20'(SCAN_DIV - 1);

  logic [31:0] disp_q, disp_d;
  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  an_q, an_d;
  logic [7:0]  seg_q, seg_d;
  logic        wrap;
  logic [3:0]  nib;

  // Active-low segment pattern for one hex digit; decimal point kept off.
  function automatic logic [7:0] hex_dec(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Read data is combinational so a read completes in the cycle it is presented.
  assign bus.rdata = (bus.seg7_cs && !bus.we) ? disp_q : 32'd0;

  // Data register, prescaler and digit index next-state.
  always_comb begin
    disp_d = disp_q;
    if (bus.seg7_cs && bus.we) begin
      disp_d = bus.wdata;
    end
    wrap  = (cnt_q == CNT_MAX);
    cnt_d = wrap ? 20'd0 : cnt_q + 20'd1;
    idx_d = wrap ? idx_q + 3'd1 : idx_q;
  end

  // Display outputs for the digit currently indexed, from the current word.
  always_comb begin
    nib   = disp_q[4*idx_q +: 4];
    an_d  = ~(8'b1 << idx_q);
    seg_d = hex_dec(nib);
`ifdef SEG7_BLANK_LEADING_ZERO_EN
    // A digit is dark when it and everything to its left is zero;
    // digit 0 always lights so a zero word still shows "0".
    if ((idx_q != 3'd0) && ((disp_q >> {idx_q, 2'b00}) == 32'd0)) begin
      an_d  = 8'hFF;
      seg_d = 8'hFF;
    end
`endif
  end

  // State and registered outputs; reset wins over any bus access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_q <= 32'd0;
      cnt_q  <= 20'd0;
      idx_q  <= 3'd0;
      an_q   <= 8'hFF;
      seg_q  <= 8'hFF;
    end else begin
      disp_q <= disp_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: doc/seg7_ctrl.md
# seg7_ctrl

Memory-mapped eight-digit seven-segment display responder on the CPU data bus. It captures a 32-bit word written while its chip select `seg7_cs` is high; the address decoder asserts `seg7_cs` for address 0x10010000. It returns the held word on reads and time-multiplexes its eight hex nibbles onto the board's common-anode display.

## Interface
- `SCAN_DIV`, default 100000: clock cycles per digit slot; legal range 1..2^20.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `seg7_cs`  in  1  chip select from the address decoder; high for address 0x10010000 with bus access.
- `we`  in  1  bus write strobe; qualifies `seg7_cs`.
- `wdata`  in  32  bus write data.
- `rdata`  out  32  read data; held word when `seg7_cs && !we`, else 0 (combinational).
- `an`  out  8  digit enables, active-low; bit i selects digit i, and digit 0 is the rightmost.
- `seg`  out  8  cathodes, active-low; `seg[7]`=dp, `seg[6:0]`=g..a.

## Operation
- The data register `disp_q[31:0]` loads `wdata` on each edge where `seg7_cs && we`. Writes without `seg7_cs` are ignored.
- The prescaler `cnt_q` counts 0..SCAN_DIV-1 and wraps to 0.
  - The digit index `idx_q[2:0]` increments at each wrap and rolls from 7 to 0.
  - With SCAN_DIV=1, `idx_q` advances every cycle.
- Outputs are registered every cycle:
  - `an <= ~(8'b1 << idx_q)`, subject to blanking (see Configuration).
  - `seg <= dec(disp_q[4*idx_q +: 4])`.
- Hex decoder values, 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E. The decimal point is always off (`seg[7]`=1).
- Boundary conditions:
  - A write on the same edge as an index advance: both take effect, and the next output cycle uses the new data with the new index.
  - Back-to-back writes: the last one wins, and every write is captured.
  - Reset mid-scan: all state returns to reset values on that edge, regardless of `seg7_cs` or `we`.

## Timing
- Reset values: `disp_q`=0, `cnt_q`=0, `idx_q`=0, `an`=8'hFF (all digits off), `seg`=8'hFF. `rdata` is 0 unless a read is presented.
- After `rst_n` is released, the first edge drives `an`=8'hFE and `seg`=8'hC0.
- Write latency:
  - Write sampled at edge N: `disp_q` and `rdata` show the new value after N.
  - `seg` reflects it at edge N+1, provided the active digit's nibble changed.
- Index latency: `idx_q` changes at the edge where `cnt_q` wraps, and `an`/`seg` follow one edge later.
- Digit slot length is exactly SCAN_DIV cycles, so a full frame is 8*SCAN_DIV cycles.
- There is no handshake and no wait state: the block accepts a write or serves a read every cycle.

## Configuration
- `SEG7_BLANK_LEADING_ZERO_EN` defined:
  - Digit i is disabled (`an[i]`=1, `seg`=8'hFF) when i > 0 and `disp_q[31:4*i]` == 0.
  - Digit 0 is always shown.
  - The blanking mask is computed from `disp_q` in the same cycle as `seg`, so it shares the same one-edge latency.
- Not defined: all eight digits are always scanned, and leading zeros display as "0" (C0).

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles -> `an`=FF, `seg`=FF, `rdata`=0. Release -> next edge `an`=FE, `seg`=C0.
- Write/read: SCAN_DIV=4; write 0x89ABCDEF with `seg7_cs`=1 -> next cycle a read gives `rdata`=0x89ABCDEF. A write with `seg7_cs`=0 and data 0x12345678 leaves it unchanged.
- Scan sequence: SCAN_DIV=4, `disp_q`=0x89ABCDEF -> `an` steps FE,FD,FB,...,7F, each held 4 cycles, with `seg` = 8E,86,A1,C6,83,88,90,80. Then `an` wraps to FE.
- Simultaneous write at wrap: write 0x00000001 on the edge where `cnt_q`=3 and `idx_q`=0 -> the following output is `an`=FD, `seg`=C0 (or blanked, see the blanking case).
- Reset mid-scan: assert `rst_n`=0 while `idx_q`=5 -> `an`=FF, `seg`=FF. After release, the scan restarts at digit 0 showing C0.
- Blanking (macro defined): `disp_q`=0x00000A05 -> only `an` slots FE (`seg` 92), FD (`seg` C0), and FB (`seg` 88) light. Slots 3..7 keep `an`=FF. Without the macro, slots 3..7 show C0.
